// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock controller.
// State encoding, blink pattern selectors and parameter defaults.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_SETUP,
    S_BLINK,
    S_RELEASE
  } state_t;

  localparam logic BLINK_ERR = 1'b0;
  localparam logic BLINK_OK  = 1'b1;

  localparam int CODE_LEN_DEF = 4;
  localparam int DIGIT_W_DEF  = 4;

endpackage

// File: rtl/digit_buffer.sv
// Entry buffer for keypad digits: shift-in, clear and digit count.
// Clear together with shift loads a single fresh digit.
module digit_buffer #(
  parameter int CODE_LEN = 4,
  parameter int DIGIT_W  = 4,
  localparam int CNT_W   = $clog2(CODE_LEN + 1),
  localparam int DATA_W  = CODE_LEN * DIGIT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_shift,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DATA_W-1:0]  o_data,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_full
);

  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  assign o_full = (r_cnt == CNT_W'(CODE_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clr && i_shift) begin
      r_data <= DATA_W'(i_digit);
      r_cnt  <= CNT_W'(1);
    end else if (i_clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_shift && !o_full) begin
      r_data <= {r_data[DATA_W-DIGIT_W-1:0], i_digit};
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_data  = r_data;
  assign o_count = r_cnt;

endmodule

// File: rtl/lock_controller.sv
// Keypad code lock: entry, compare/program, timeout and blink handshake.
// blink_start is registered so async reset drops it immediately.
module lock_controller
  import lock_pkg::*;
#(
  parameter int          CODE_LEN = CODE_LEN_DEF,
  parameter int          DIGIT_W  = DIGIT_W_DEF,
  parameter logic [31:0] TIMEOUT  = 32'd60000000
) (
  input  logic               hwclk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               prog_mode,
  input  logic               blink_done,
  output logic               blink_start,
  output logic               blink_type,
  output logic               unlocked,
  output logic               busy
);

  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int DATA_W = CODE_LEN * DIGIT_W;

  state_t            r_state, w_state_n;
  logic [DATA_W-1:0] r_code, w_code_n;
  logic [31:0]       r_tmo, w_tmo_n;
  logic              r_type, w_type_n;
  logic              r_unl, w_unl_n;
  logic              r_start;

  logic              w_clr, w_shift;
  logic [DATA_W-1:0] w_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;

  logic w_ok, w_last, w_match;

  assign w_ok    = key_valid && (key_digit <= DIGIT_W'(9));
  assign w_last  = (w_count == CNT_W'(CODE_LEN - 1));
  assign w_match = w_full && (w_data == r_code);

  digit_buffer #(
    .CODE_LEN (CODE_LEN),
    .DIGIT_W  (DIGIT_W)
  ) u_buf (
    .clk     (hwclk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_digit (key_digit),
    .o_data  (w_data),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_comb begin
    w_state_n = r_state;
    w_code_n  = r_code;
    w_tmo_n   = r_tmo;
    w_type_n  = r_type;
    w_unl_n   = r_unl;
    w_clr     = 1'b0;
    w_shift   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_ok) begin
          w_clr     = 1'b1;
          w_shift   = 1'b1;
          w_unl_n   = 1'b0;
          w_tmo_n   = '0;
          w_state_n = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // A digit in the expiry cycle wins over the timeout
        if (w_ok) begin
          w_shift = 1'b1;
          w_tmo_n = '0;
          if (w_last) w_state_n = S_CHECK;
        end else if (r_tmo == TIMEOUT - 32'd1) begin
          w_clr     = 1'b1;
          w_type_n  = BLINK_ERR;
          w_state_n = S_SETUP;
        end else begin
          w_tmo_n = r_tmo + 32'd1;
        end
      end
      S_CHECK: begin
        w_clr = 1'b1;
        if (prog_mode) begin
          w_code_n = w_data;
          w_type_n = BLINK_OK;
        end else if (w_match) begin
          w_unl_n  = 1'b1;
          w_type_n = BLINK_OK;
        end else begin
          w_unl_n  = 1'b0;
          w_type_n = BLINK_ERR;
        end
        w_state_n = S_SETUP;
      end
      S_SETUP: w_state_n = S_BLINK;
      S_BLINK: begin
        if (blink_done) w_state_n = S_RELEASE;
      end
      S_RELEASE: begin
        if (!blink_done) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_tmo   <= '0;
      r_type  <= BLINK_ERR;
      r_unl   <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_code  <= w_code_n;
      r_tmo   <= w_tmo_n;
      r_type  <= w_type_n;
      r_unl   <= w_unl_n;
      r_start <= (w_state_n == S_BLINK);
    end
  end

  assign blink_start = r_start;
  assign blink_type  = r_type;
  assign unlocked    = r_unl;
  assign busy        = (r_state != S_IDLE) && (r_state != S_ENTRY);

endmodule

// File: tb/tb_lock_controller.sv
// Self-checking bench for lock_controller with a sequence-level lock model.
// Emulates the blinker handshake and drives random code entries.
module tb_lock_controller;

  localparam int TO = 100;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       prog_mode = 1'b0;
  logic       blink_done = 1'b0;
  logic       blink_start, blink_type, unlocked, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_code = 16'h0000;
  logic        m_unl = 1'b0;

  lock_controller #(
    .CODE_LEN (4),
    .DIGIT_W  (4),
    .TIMEOUT  (32'd100)
  ) dut (
    .hwclk       (hwclk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .prog_mode   (prog_mode),
    .blink_done  (blink_done),
    .blink_start (blink_start),
    .blink_type  (blink_type),
    .unlocked    (unlocked),
    .busy        (busy)
  );

  always #5 hwclk = ~hwclk;

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge hwclk);
    key_valid = 1'b0;
  endtask

  task automatic do_blink(input logic t, input logic u, input int lat);
    int n;
    logic pt;
    n = 0;
    pt = blink_type;
    while (blink_start !== 1'b1 && n < 10) begin
      pt = blink_type;
      @(negedge hwclk);
      n++;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL blink_latency got %0d exp %0d", n, lat);
    end
    checks++;
    if (pt !== t) begin
      errors++;
      $display("FAIL setup_type got %b exp %b", pt, t);
    end
    checks++;
    if (unlocked !== u) begin
      errors++;
      $display("FAIL unlocked got %b exp %b", unlocked, u);
    end
    for (int k = 0; k < 3; k++) begin
      press(4'($urandom_range(0, 15)));
      checks++;
      if ({blink_start, blink_type, busy} !== {1'b1, t, 1'b1}) begin
        errors++;
        $display("FAIL blink_hold got %b%b%b exp 1%b1",
                 blink_start, blink_type, busy, t);
      end
    end
    blink_done = 1'b1;
    repeat (2) begin
      @(negedge hwclk);
      checks++;
      if ({blink_start, busy} !== 2'b01) begin
        errors++;
        $display("FAIL release got %b%b exp 01", blink_start, busy);
      end
    end
    blink_done = 1'b0;
    @(negedge hwclk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL back_idle got %b exp 0", busy);
    end
  endtask

  task automatic session(input logic [15:0] seq, input logic prog,
                         input logic junk);
    logic t;
    for (int i = 0; i < 4; i++) begin
      if (junk && $urandom_range(0, 1) == 1)
        press(4'($urandom_range(10, 15)));
      prog_mode = (i < 3) ? 1'($urandom_range(0, 1)) : prog;
      press(seq[15-4*i -: 4]);
      if (i == 0) begin
        m_unl = 1'b0;
        checks++;
        if (unlocked !== 1'b0) begin
          errors++;
          $display("FAIL first_digit_clr got %b exp 0", unlocked);
        end
      end
      checks++;
      if (busy !== (i == 3)) begin
        errors++;
        $display("FAIL entry_busy d%0d got %b exp %b", i, busy, i == 3);
      end
    end
    if (prog) begin
      m_code = seq;
      t = 1'b1;
    end else if (seq == m_code) begin
      m_unl = 1'b1;
      t = 1'b1;
    end else begin
      m_unl = 1'b0;
      t = 1'b0;
    end
    do_blink(t, m_unl, 2);
    prog_mode = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({blink_start, blink_type, unlocked, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got %b%b%b%b exp 0000",
               blink_start, blink_type, unlocked, busy);
    end
    @(negedge hwclk);
    rst_n = 1'b1;
    @(negedge hwclk);
  endtask

  task automatic test_default_code;
    session(16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_program;
    session(16'h1234, 1'b1, 1'b0);
    session(16'h1235, 1'b0, 1'b0);
    session(16'h1234, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    press(4'd1);
    m_unl = 1'b0;
    press(4'd2);
    for (int k = 1; k < TO; k++) begin
      if (k == 50) press(4'hA);
      else @(negedge hwclk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL pre_expiry_busy got %b exp 0", busy);
    end
    @(negedge hwclk);
    checks++;
    if ({busy, blink_start, blink_type} !== 3'b100) begin
      errors++;
      $display("FAIL expiry_setup got %b%b%b exp 100",
               busy, blink_start, blink_type);
    end
    do_blink(1'b0, 1'b0, 1);
    session(m_code, 1'b0, 1'b0);
  endtask

  task automatic test_ignored;
    session(m_code ^ 16'h0001, 1'b0, 1'b1);
    session(m_code, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic [15:0] s;
    logic p;
    for (int r = 0; r < 8; r++) begin
      p = ($urandom_range(0, 2) == 0);
      if (!p && $urandom_range(0, 1) == 1) s = m_code;
      else
        for (int i = 0; i < 4; i++) s[4*i +: 4] = 4'($urandom_range(0, 9));
      session(s, p, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_blink;
    int n;
    for (int i = 0; i < 4; i++) press(4'd0);
    n = 0;
    while (blink_start !== 1'b1 && n < 10) begin
      @(negedge hwclk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({blink_start, busy, unlocked} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got %b%b%b exp 000",
               blink_start, busy, unlocked);
    end
    m_code = 16'h0000;
    m_unl = 1'b0;
    @(negedge hwclk);
    rst_n = 1'b1;
    @(negedge hwclk);
    session(16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_default_code;
    test_program;
    test_timeout;
    test_ignored;
    test_random;
    test_reset_mid_blink;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
